alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  ALU reservation station: the issue side feeding the ALU and the consumer of its result broadcast.
//  - Accepts decoded ops from the dispatcher.
//  - Snoops the ALU and LSB result broadcasts to wake waiting operands.
//  - Each cycle, sends one ready entry to the ALU as rs1/rs2/op/robid.
//  - op==0 marks an idle cycle on the ALU inputs.
// PARAMETERS
//  RS_SIZE    8  number of entries (power of two)
//  RS_ADDR_W  3  clog2(RS_SIZE)
// PORTS
//  clk_in       in   1          clock, rising edge
//  rst_in       in   1          asynchronous, active-low reset
//  rdy_in       in   1          global enable; low = freeze state
//  clear_in     in   1          mispredict flush
//  iss_valid    in   1          issue request
//  iss_op       in   6          opcode (`Lui..`Sub from const.v; never 0)
//  iss_vj       in   32         operand j value (valid when !iss_qj_busy)
//  iss_vk       in   32         operand k value (valid when !iss_qk_busy)
//  iss_qj_busy  in   1          operand j waits on tag iss_qj
//  iss_qk_busy  in   1          operand k waits on tag iss_qk
//  iss_qj       in   `RoB_addr  producer tag for operand j
//  iss_qk       in   `RoB_addr  producer tag for operand k
//  iss_robid    in   `RoB_addr  destination RoB tag
//  rs_full      out  1          combinational; no free entry
//  alu_bc_valid in   1          ALU broadcast valid
//  alu_bc_robid in   `RoB_addr  ALU broadcast tag
//  alu_bc_data  in   32         ALU broadcast result
//  lsb_bc_valid in   1          LSB broadcast valid
//  lsb_bc_robid in   `RoB_addr  LSB broadcast tag
//  lsb_bc_data  in   32         LSB broadcast result
//  alu_rs1      out  32         registered, to ALU rs1
//  alu_rs2      out  32         registered, to ALU rs2
//  alu_op       out  6          registered, to ALU op; 0 = no op
//  alu_robid    out  `RoB_addr  registered, to ALU robid
// BEHAVIOUR
//  - Reset: all entries not busy; all outputs 0.
//  - Entry state: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, robid.
//  - Issue
//    - Taken at the edge when rdy_in && iss_valid && !rs_full && !clear_in.
//    - Written into the lowest-index free entry.
//    - Issue while rs_full: silently dropped (dispatcher protocol violation).
//  - Issue-time capture: if iss_qj_busy and a valid broadcast carries tag iss_qj in the same cycle:
//    - vj = that broadcast's data; qj_busy = 0.
//    - Same rule for k. ALU broadcast wins if both ports carry the tag.
//  - Wakeup: for each busy entry with qj_busy and qj == a valid broadcast tag:
//    - vj <= data; qj_busy <= 0. Same for k.
//    - Both operands may wake in one cycle.
//  - Ready = busy && !qj_busy && !qk_busy, evaluated on registered state only.
//    - An entry woken at edge N is dispatchable at edge N+1 at the earliest.
//  - Dispatch at each edge with rdy_in && !clear_in:
//    - Select one ready entry; drive alu_* from it; free the entry.
//    - No ready entry: alu_op <= 0; other alu_* outputs hold.
//  - Latency: issue with both operands ready at edge N → alu_op valid after edge N+1 → ALU result after edge N+2.
//  - Slot reuse: a dispatched entry is free for issue in the following cycle.
//    - rs_full is computed from registered busy bits; no same-cycle reuse.
//  - clear_in (synchronous): all busy <= 0; alu_op <= 0. Overrides issue, wakeup and dispatch in that cycle.
//  - rdy_in low: all state held; alu_op <= 0, so the ALU never re-executes a stale op.
//  - Reset mid-operation: asynchronous return to reset state; in-flight entries lost.
// CONFIGURATION
//  RS_AGE_SELECT_EN
//    - Defined: per-entry RS_ADDR_W-bit age counter, zeroed on issue.
//      - Every other busy entry increments its age on issue, saturating.
//      - Dispatch selects the ready entry with the largest age; ties go to the lower index.
//    - Undefined: dispatch selects the lowest-index ready entry; no age state.
// STRUCTURE
//  - const.v holds the opcode defines, `RoB_addr and an RS_ENTRY width constant; no new package.
//  - One sub-module: rs_select, a combinational priority/age picker.
//    - Inputs: ready[RS_SIZE] and the optional ages.
//    - Outputs: a found flag and an RS_ADDR_W index.
//    - Reused for the free-slot search with the age inputs tied to 0.
// TESTING
//  - Ready issue: `Add, vj=5, vk=7, robid=3 at cycle 0 → cycle 1: alu_op=`Add, rs1=5, rs2=7, alu_robid=3; cycle 2: alu_op=0.
//  - Wakeup: `Sub issued with qj=2 busy, vk=1.
//    - alu_bc robid=2, data=10 at cycle 4 → dispatch at cycle 5 with rs1=10, rs2=1.
//  - Issue-time capture: issue with qk=6 busy while lsb_bc robid=6, data=0xFFFF_FFFF in the same cycle.
//    - Dispatched next cycle with rs2=0xFFFF_FFFF.
//  - Full: 8 blocked issues → rs_full=1; 9th issue dropped.
//    - Wake tag of entry 0 → rs_full=0 the cycle after its dispatch.
//  - clear_in with 5 busy entries → next cycle all free, alu_op=0, rs_full=0.
//    - rdy_in low for 3 cycles → alu_op=0 and state unchanged.
//  - RS_AGE_SELECT_EN: entries 2 then 0 become ready in the same cycle, entry 2 issued earlier → entry 2 dispatched first.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared definitions for the ALU reservation station.
//   - Opcode codes (OP_LUI..OP_SUB); 0 is reserved for "no op" on the ALU inputs.
//   - ROB_W: width of a reorder-buffer tag.
//   - opnd_t / rs_entry_t: one station entry. RS_ENTRY_W is its packed width.
//   - snoop(): resolves a waiting operand against the two result broadcasts.
package alu_rs_pkg;

   localparam int XLEN  = 32;
   localparam int OP_W  = 6;
   localparam int ROB_W = 4;

   localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
   localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
   localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'd3;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'd4;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'd5;
   localparam logic [OP_W-1:0] OP_XORI  = 6'd6;
   localparam logic [OP_W-1:0] OP_ORI   = 6'd7;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'd8;
   localparam logic [OP_W-1:0] OP_SLLI  = 6'd9;
   localparam logic [OP_W-1:0] OP_SRLI  = 6'd10;
   localparam logic [OP_W-1:0] OP_SRAI  = 6'd11;
   localparam logic [OP_W-1:0] OP_ADD   = 6'd12;
   localparam logic [OP_W-1:0] OP_SUB   = 6'd13;

   // Operand slot: busy means the value is still owed by a producer.
   typedef struct packed {
      logic            busy;
      logic [XLEN-1:0] val;
   } opnd_t;

   typedef struct packed {
      logic             busy;
      logic [OP_W-1:0]  op;
      opnd_t            j;
      opnd_t            k;
      logic [ROB_W-1:0] qj;
      logic [ROB_W-1:0] qk;
      logic [ROB_W-1:0] robid;
   } rs_entry_t;

   localparam int RS_ENTRY_W = $bits(rs_entry_t);

   // Capture a broadcast result into a waiting operand. ALU port has priority
   // when both ports carry the same tag.
   function automatic opnd_t snoop(input opnd_t            cur,
                                   input logic [ROB_W-1:0] tag,
                                   input logic             av,
                                   input logic [ROB_W-1:0] ar,
                                   input logic [XLEN-1:0]  ad,
                                   input logic             lv,
                                   input logic [ROB_W-1:0] lr,
                                   input logic [XLEN-1:0]  ld);
      opnd_t res;
      res = cur;
      if (cur.busy) begin
         if (av && ar == tag) begin
            res.busy = 1'b0;
            res.val  = ad;
         end else if (lv && lr == tag) begin
            res.busy = 1'b0;
            res.val  = ld;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_rs_select.sv
// rs_select: combinational picker over N request bits.
//   i_req   : candidate bitmap
//   i_age   : per-candidate age; tie to 0 for a plain lowest-index search
//   o_found : at least one candidate
//   o_idx   : chosen index (largest age, ties to lowest index); 0 if none
module rs_select #(
   parameter int N  = 8,
   parameter int AW = 3
) (
   input  logic [N-1:0]         i_req,
   input  logic [N-1:0][AW-1:0] i_age,
   output logic                 o_found,
   output logic [AW-1:0]        o_idx
);

   logic [AW-1:0] w_best_age;

   always_comb begin
      o_found    = 1'b0;
      o_idx      = '0;
      w_best_age = '0;
      // Strict '>' keeps the lower index on equal ages.
      for (int i = 0; i < N; i++) begin
         if (i_req[i] && (!o_found || i_age[i] > w_best_age)) begin
            o_found    = 1'b1;
            o_idx      = AW'(i);
            w_best_age = i_age[i];
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station.
//   Accepts decoded ops (iss_*), snoops ALU/LSB broadcasts (alu_bc_*, lsb_bc_*)
//   to wake waiting operands, and dispatches one ready entry per cycle on the
//   registered alu_* outputs (alu_op == 0 means idle). rs_full is combinational
//   from the registered busy bits.
//   clk_in / rst_in (async, active low) / rdy_in (freeze when low) / clear_in (flush).
// Optional build macro:
//   RS_AGE_SELECT_EN - dispatch picks the oldest ready entry via per-entry age
//                      counters; otherwise the lowest-index ready entry wins.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE   = 8,
   parameter int RS_ADDR_W = 3
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear_in,
   input  logic             iss_valid,
   input  logic [OP_W-1:0]  iss_op,
   input  logic [XLEN-1:0]  iss_vj,
   input  logic [XLEN-1:0]  iss_vk,
   input  logic             iss_qj_busy,
   input  logic             iss_qk_busy,
   input  logic [ROB_W-1:0] iss_qj,
   input  logic [ROB_W-1:0] iss_qk,
   input  logic [ROB_W-1:0] iss_robid,
   output logic             rs_full,
   input  logic             alu_bc_valid,
   input  logic [ROB_W-1:0] alu_bc_robid,
   input  logic [XLEN-1:0]  alu_bc_data,
   input  logic             lsb_bc_valid,
   input  logic [ROB_W-1:0] lsb_bc_robid,
   input  logic [XLEN-1:0]  lsb_bc_data,
   output logic [XLEN-1:0]  alu_rs1,
   output logic [XLEN-1:0]  alu_rs2,
   output logic [OP_W-1:0]  alu_op,
   output logic [ROB_W-1:0] alu_robid
);

   rs_entry_t r_ent [RS_SIZE];

   logic [RS_SIZE-1:0]                w_busy;
   logic [RS_SIZE-1:0]                w_ready;
   logic [RS_SIZE-1:0][RS_ADDR_W-1:0] w_age;
   logic                              w_free_found;
   logic [RS_ADDR_W-1:0]              w_free_idx;
   logic                              w_dsp_found;
   logic [RS_ADDR_W-1:0]              w_dsp_idx;
   logic                              w_iss_take;
   logic                              w_run;
   rs_entry_t                         w_new;

   logic [XLEN-1:0]  r_rs1;
   logic [XLEN-1:0]  r_rs2;
   logic [OP_W-1:0]  r_op;
   logic [ROB_W-1:0] r_robid;

   // Readiness uses registered state only, so a wakeup never dispatches in
   // the same edge it lands.
   always_comb begin
      w_busy  = '0;
      w_ready = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         w_busy[i]  = r_ent[i].busy;
         w_ready[i] = r_ent[i].busy && !r_ent[i].j.busy && !r_ent[i].k.busy;
      end
   end

   rs_select #(.N(RS_SIZE), .AW(RS_ADDR_W)) u_free_sel (
      .i_req   (~w_busy),
      .i_age   ('0),
      .o_found (w_free_found),
      .o_idx   (w_free_idx)
   );

   rs_select #(.N(RS_SIZE), .AW(RS_ADDR_W)) u_dsp_sel (
      .i_req   (w_ready),
      .i_age   (w_age),
      .o_found (w_dsp_found),
      .o_idx   (w_dsp_idx)
   );

   assign rs_full    = !w_free_found;
   assign w_run      = rdy_in && !clear_in;
   assign w_iss_take = w_run && iss_valid && w_free_found;

   // New entry, with operands already resolved against this cycle's broadcasts.
   always_comb begin
      w_new       = '0;
      w_new.busy  = 1'b1;
      w_new.op    = iss_op;
      w_new.qj    = iss_qj;
      w_new.qk    = iss_qk;
      w_new.robid = iss_robid;
      w_new.j     = snoop('{busy: iss_qj_busy, val: iss_vj}, iss_qj,
                          alu_bc_valid, alu_bc_robid, alu_bc_data,
                          lsb_bc_valid, lsb_bc_robid, lsb_bc_data);
      w_new.k     = snoop('{busy: iss_qk_busy, val: iss_vk}, iss_qk,
                          alu_bc_valid, alu_bc_robid, alu_bc_data,
                          lsb_bc_valid, lsb_bc_robid, lsb_bc_data);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_op    <= '0;
         r_robid <= '0;
      end else if (!rdy_in) begin
         r_op <= '0;
      end else if (clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
         r_op <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_ent[i].busy) begin
               r_ent[i].j <= snoop(r_ent[i].j, r_ent[i].qj,
                                   alu_bc_valid, alu_bc_robid, alu_bc_data,
                                   lsb_bc_valid, lsb_bc_robid, lsb_bc_data);
               r_ent[i].k <= snoop(r_ent[i].k, r_ent[i].qk,
                                   alu_bc_valid, alu_bc_robid, alu_bc_data,
                                   lsb_bc_valid, lsb_bc_robid, lsb_bc_data);
            end
         end
         if (w_dsp_found) begin
            r_ent[w_dsp_idx].busy <= 1'b0;
            r_rs1   <= r_ent[w_dsp_idx].j.val;
            r_rs2   <= r_ent[w_dsp_idx].k.val;
            r_op    <= r_ent[w_dsp_idx].op;
            r_robid <= r_ent[w_dsp_idx].robid;
         end else begin
            r_op <= '0;
         end
         // The free slot is non-busy, so it never collides with the
         // dispatched or woken entries above.
         if (w_iss_take) r_ent[w_free_idx] <= w_new;
      end
   end

`ifdef RS_AGE_SELECT_EN
   logic [RS_SIZE-1:0][RS_ADDR_W-1:0] r_age;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_age <= '0;
      end else if (w_iss_take) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (RS_ADDR_W'(i) == w_free_idx)
               r_age[i] <= '0;
            else if (w_busy[i] && r_age[i] != '1)
               r_age[i] <= r_age[i] + 1'b1;
         end
      end
   end

   assign w_age = r_age;
`else
   assign w_age = '0;
`endif

   assign alu_rs1   = r_rs1;
   assign alu_rs2   = r_rs2;
   assign alu_op    = r_op;
   assign alu_robid = r_robid;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
   import alu_rs_pkg::*;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b0;
   logic             rdy_in, clear_in, iss_valid, iss_qj_busy, iss_qk_busy;
   logic [OP_W-1:0]  iss_op;
   logic [XLEN-1:0]  iss_vj, iss_vk;
   logic [ROB_W-1:0] iss_qj, iss_qk, iss_robid;
   logic             rs_full;
   logic             alu_bc_valid, lsb_bc_valid;
   logic [ROB_W-1:0] alu_bc_robid, lsb_bc_robid;
   logic [XLEN-1:0]  alu_bc_data, lsb_bc_data;
   logic [XLEN-1:0]  alu_rs1, alu_rs2;
   logic [OP_W-1:0]  alu_op;
   logic [ROB_W-1:0] alu_robid;

   always #5 clk_in = ~clk_in;

   alu_rs dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_vj(iss_vj), .iss_vk(iss_vk),
      .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy),
      .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_robid(iss_robid), .rs_full(rs_full),
      .alu_bc_valid(alu_bc_valid), .alu_bc_robid(alu_bc_robid), .alu_bc_data(alu_bc_data),
      .lsb_bc_valid(lsb_bc_valid), .lsb_bc_robid(lsb_bc_robid), .lsb_bc_data(lsb_bc_data),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_robid(alu_robid)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic idle_in();
      rdy_in = 1'b1; clear_in = 1'b0; iss_valid = 1'b0; iss_op = OP_NOP;
      iss_vj = '0; iss_vk = '0; iss_qj_busy = 1'b0; iss_qk_busy = 1'b0;
      iss_qj = '0; iss_qk = '0; iss_robid = '0;
      alu_bc_valid = 1'b0; alu_bc_robid = '0; alu_bc_data = '0;
      lsb_bc_valid = 1'b0; lsb_bc_robid = '0; lsb_bc_data = '0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic iss(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjb, input logic [3:0] qj, input logic qkb,
                      input logic [3:0] qk, input logic [3:0] rob);
      iss_valid = 1'b1; iss_op = op; iss_vj = vj; iss_vk = vk;
      iss_qj_busy = qjb; iss_qj = qj; iss_qk_busy = qkb; iss_qk = qk; iss_robid = rob;
   endtask

   task automatic abc(input logic [3:0] t, input logic [31:0] d);
      alu_bc_valid = 1'b1; alu_bc_robid = t; alu_bc_data = d;
   endtask

   task automatic lbc(input logic [3:0] t, input logic [31:0] d);
      lsb_bc_valid = 1'b1; lsb_bc_robid = t; lsb_bc_data = d;
   endtask

   task automatic chk_out(input string nm, input logic [5:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [3:0] rob);
      chk({nm, ".op"}, 32'(alu_op), 32'(op));
      chk({nm, ".rs1"}, alu_rs1, r1);
      chk({nm, ".rs2"}, alu_rs2, r2);
      chk({nm, ".robid"}, 32'(alu_robid), 32'(rob));
   endtask

   // One row = inputs applied for one edge + outputs expected after it.
   typedef struct {
      logic        iv;
      logic [5:0]  op;
      logic [31:0] vj, vk;
      logic        qjb;
      logic [3:0]  qj;
      logic        qkb;
      logic [3:0]  qk, rob;
      logic        av;
      logic [3:0]  ar;
      logic [31:0] ad;
      logic        lv;
      logic [3:0]  lr;
      logic [31:0] ld;
      logic [5:0]  eop;
      logic [31:0] e1, e2;
      logic [3:0]  er;
   } vec_t;

   function automatic vec_t V(input logic iv, input logic [5:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic qjb, input logic [3:0] qj,
                              input logic qkb, input logic [3:0] qk, input logic [3:0] rob,
                              input logic av, input logic [3:0] ar, input logic [31:0] ad,
                              input logic lv, input logic [3:0] lr, input logic [31:0] ld,
                              input logic [5:0] eop, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [3:0] er);
      vec_t r;
      r.iv = iv; r.op = op; r.vj = vj; r.vk = vk; r.qjb = qjb; r.qj = qj;
      r.qkb = qkb; r.qk = qk; r.rob = rob; r.av = av; r.ar = ar; r.ad = ad;
      r.lv = lv; r.lr = lr; r.ld = ld; r.eop = eop; r.e1 = e1; r.e2 = e2; r.er = er;
      return r;
   endfunction

   localparam logic [31:0] ONES = 32'hFFFF_FFFF;
   vec_t tbl[15];

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle_in();
      //      iv op      vj vk    qjb qj qkb qk rob  av ar ad     lv lr ld    eop     e1    e2    er
      tbl[0]  = V(1, OP_ADD, 5, 7,   0, 0, 0, 0, 3,  0, 0, 0,     0, 0, 0,    OP_NOP, 0,    0,    0);
      tbl[1]  = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_ADD, 5,    7,    3);
      tbl[2]  = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_NOP, 5,    7,    3);
      tbl[3]  = V(1, OP_SUB, 0, 1,   1, 2, 0, 0, 5,  0, 0, 0,     0, 0, 0,    OP_NOP, 5,    7,    3);
      tbl[4]  = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  1, 9, 99,    0, 0, 0,    OP_NOP, 5,    7,    3);
      tbl[5]  = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  1, 2, 10,    0, 0, 0,    OP_NOP, 5,    7,    3);
      tbl[6]  = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_SUB, 10,   1,    5);
      tbl[7]  = V(1, OP_ADD, 4, 0,   0, 0, 1, 6, 7,  0, 0, 0,     1, 6, ONES, OP_NOP, 10,   1,    5);
      tbl[8]  = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_ADD, 4,    ONES, 7);
      tbl[9]  = V(1, OP_SUB, 0, 3,   1, 9, 0, 0, 1,  1, 9, 100,   1, 9, 200,  OP_NOP, 4,    ONES, 7);
      tbl[10] = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_SUB, 100,  3,    1);
      tbl[11] = V(1, OP_ADD, 0, 0,   1, 1, 1, 2, 4,  0, 0, 0,     0, 0, 0,    OP_NOP, 100,  3,    1);
      tbl[12] = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  1, 1, 11,    1, 2, 22,   OP_NOP, 100,  3,    1);
      tbl[13] = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_ADD, 11,   22,   4);
      tbl[14] = V(0, OP_NOP, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,     0, 0, 0,    OP_NOP, 11,   22,   4);

      // Reset state
      #12;
      chk_out("reset", OP_NOP, 0, 0, 0);
      chk("reset.full", 32'(rs_full), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;

      // Table: ready issue, wakeup, issue-time capture, ALU priority, dual wake
      for (int r = 0; r < 15; r++) begin
         if (tbl[r].iv) iss(tbl[r].op, tbl[r].vj, tbl[r].vk, tbl[r].qjb, tbl[r].qj,
                            tbl[r].qkb, tbl[r].qk, tbl[r].rob);
         if (tbl[r].av) abc(tbl[r].ar, tbl[r].ad);
         if (tbl[r].lv) lbc(tbl[r].lr, tbl[r].ld);
         tick();
         idle_in();
         chk_out($sformatf("row%0d", r), tbl[r].eop, tbl[r].e1, tbl[r].e2, tbl[r].er);
         chk($sformatf("row%0d.full", r), 32'(rs_full), 0);
      end

      // Full: 8 blocked entries; entry i waits on tag i, robid 8+i
      for (int i = 0; i < 8; i++) begin
         iss(OP_LUI + 6'(i), 0, 32'(i), 1, 4'(i), 0, 0, 4'(8 + i));
         tick();
         idle_in();
         chk($sformatf("fill%0d.full", i), 32'(rs_full), (i == 7) ? 1 : 0);
      end
      iss(OP_ADD, 1, 1, 0, 0, 0, 0, 15);   // dropped: station full
      tick();
      idle_in();
      chk("drop.full", 32'(rs_full), 1);
      tick();
      chk("drop.op", 32'(alu_op), 0);
      abc(0, 42);
      tick();
      idle_in();
      chk("wake0.full", 32'(rs_full), 1);
      chk("wake0.op", 32'(alu_op), 0);
      tick();
      chk_out("disp0", OP_LUI, 42, 0, 8);
      chk("disp0.full", 32'(rs_full), 0);

      // Clear: flush 7 leftovers, then 4 blocked + 1 ready, flush before dispatch
      clear_in = 1'b1;
      tick();
      idle_in();
      chk("clr1.full", 32'(rs_full), 0);
      chk("clr1.op", 32'(alu_op), 0);
      for (int i = 1; i <= 4; i++) begin
         iss(OP_ADDI, 0, 0, 1, 4'(i), 0, 0, 4'(i));
         tick();
         idle_in();
      end
      iss(OP_ADD, 2, 3, 0, 0, 0, 0, 5);
      tick();
      idle_in();
      clear_in = 1'b1;
      iss(OP_SUB, 8, 8, 0, 0, 0, 0, 6);    // ignored: clear wins
      abc(1, 77);
      tick();
      idle_in();
      chk("clr2.op", 32'(alu_op), 0);
      chk("clr2.full", 32'(rs_full), 0);
      abc(2, 5);
      lbc(3, 6);
      tick();
      idle_in();
      chk("postclr1.op", 32'(alu_op), 0);
      tick();
      chk("postclr2.op", 32'(alu_op), 0);

      // rdy_in low for 3 cycles
      iss(OP_ADD, 1, 2, 0, 0, 0, 0, 6);
      tick();
      idle_in();
      iss(OP_SUB, 9, 4, 0, 0, 0, 0, 7);
      tick();
      idle_in();
      chk_out("rdyA", OP_ADD, 1, 2, 6);
      for (int i = 0; i < 3; i++) begin
         rdy_in = 1'b0;
         iss(OP_ADD, 3, 3, 0, 0, 0, 0, 8);  // must not be taken while frozen
         tick();
         chk_out($sformatf("frz%0d", i), OP_NOP, 1, 2, 6);
      end
      idle_in();
      tick();
      chk_out("rdyB", OP_SUB, 9, 4, 7);
      tick();
      chk("rdyC.op", 32'(alu_op), 0);

      // Select order: entry 2 older than a re-issued entry 0, both wake together
      iss(OP_ADD, 0, 0, 1, 1, 0, 0, 1); tick(); idle_in();
      iss(OP_ADD, 0, 0, 1, 2, 0, 0, 2); tick(); idle_in();
      iss(OP_ADD, 0, 0, 1, 3, 0, 0, 3); tick(); idle_in();
      abc(1, 5); tick(); idle_in();
      tick();
      chk("ord.first_free.rob", 32'(alu_robid), 1);
      iss(OP_ADD, 0, 0, 1, 4, 0, 0, 4); tick(); idle_in();
      abc(3, 30);
      lbc(4, 40);
      tick();
      idle_in();
      tick();
`ifdef RS_AGE_SELECT_EN
      chk_out("ord.a", OP_ADD, 30, 0, 3);
      tick();
      chk_out("ord.b", OP_ADD, 40, 0, 4);
`else
      chk_out("ord.a", OP_ADD, 40, 0, 4);
      tick();
      chk_out("ord.b", OP_ADD, 30, 0, 3);
`endif

      // Asynchronous reset mid-operation (entry 1 still waiting on tag 2)
      @(negedge clk_in);
      #2;
      rst_in = 1'b0;
      #1;
      chk_out("arst", OP_NOP, 0, 0, 0);
      chk("arst.full", 32'(rs_full), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      abc(2, 9);
      tick();
      idle_in();
      tick();
      chk("arst.lost.op", 32'(alu_op), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
